ddc_tail_capture_ctrl: RTL and testbench



---
 rtl/ddc_tail_capture_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ddc_tail_capture_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_tail_capture_ctrl.sv
// Threshold-triggered capture sequencer for the DDC tail sample stream.
// Ports: clk/reset, in_data/in_valid sample stream, Avalon-MM slave
// (address, chipselect, read, write_n, writedata, readdata), irq level.
module ddc_tail_capture_ctrl #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    state_t state, state_nx;

    logic [DATA_W-1:0] thresh;
    logic [ADDR_W:0]   length;
    logic [ADDR_W:0]   eff_len;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              irq_en;
    logic              done;
    logic              underflow;
    logic              prev_below;

    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_en, rd_en;
    logic arm, abort, trigger;
    logic clr_buf, sample_wr, set_done, clr_uflow;
    logic pop, uflow_set;
    logic [31:0] rdata_nx;

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:DATA_W];

    assign wr_en = chipselect && !write_n;
    assign rd_en = chipselect && read;

    assign arm   = wr_en && (address == 3'd0) && writedata[0];
    assign abort = wr_en && (address == 3'd0) && writedata[1];

    // Rising crossing only: previous sample below, current at/above.
    assign trigger = in_valid && prev_below && (in_data >= thresh);

    // 0 or anything beyond the buffer means "fill the whole buffer".
    assign eff_len = ((length == '0) || (length > DEPTH_L)) ? DEPTH_L : length;
    assign count_inc = count + ONE_L;

    assign pop = rd_en && (address == 3'd4) && (state == DONE) && (count != '0);
    assign uflow_set = rd_en && (address == 3'd4) && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        clr_buf   = 1'b0;
        sample_wr = 1'b0;
        set_done  = 1'b0;
        clr_uflow = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            clr_buf  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        clr_buf   = 1'b1;
                        clr_uflow = 1'b1;
                        state_nx  = ARMED;
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        sample_wr = 1'b1;
                        if (eff_len == ONE_L) begin
                            state_nx = DONE;
                            set_done = 1'b1;
                        end else begin
                            state_nx = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        sample_wr = 1'b1;
                        // >= so a live LENGTH cut below count ends on this write.
                        if (count_inc >= eff_len) begin
                            state_nx = DONE;
                            set_done = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (arm) begin
                        clr_buf  = 1'b1;
                        state_nx = ARMED;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Pointers and fill count; capture writes and pops never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr_buf) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (sample_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count_inc;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - ONE_L;
        end
    end

    always_ff @(posedge clk) begin
        if (sample_wr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_below <= 1'b1;
        end else if (in_valid) begin
            prev_below <= (in_data < thresh);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            thresh <= '0;
            length <= '0;
        end else if (wr_en) begin
            case (address)
                3'd0: irq_en <= writedata[2];
                3'd2: thresh <= writedata[DATA_W-1:0];
                3'd3: length <= writedata[ADDR_W:0];
                default: ;
            endcase
        end
    end

    // Hardware set beats a same-cycle software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (set_done) begin
                done <= 1'b1;
            end else if (wr_en && (address == 3'd1) && writedata[2]) begin
                done <= 1'b0;
            end
            if (uflow_set) begin
                underflow <= 1'b1;
            end else if (clr_uflow ||
                         (wr_en && (address == 3'd1) && writedata[3])) begin
                underflow <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_nx = '0;
        case (address)
            3'd0: rdata_nx[2] = irq_en;
            3'd1: rdata_nx[3:0] = {underflow, done, state};
            3'd2: rdata_nx[DATA_W-1:0] = thresh;
            3'd3: rdata_nx[ADDR_W:0] = length;
            3'd4: if (pop) rdata_nx[DATA_W-1:0] = mem[rd_ptr];
            3'd5: rdata_nx[ADDR_W:0] = count;
            default: rdata_nx = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rdata_nx;
        end
    end

    assign irq = done & irq_en;

endmodule

// File: tb/tb_ddc_tail_capture_ctrl.sv
// Testbench for ddc_tail_capture_ctrl: directed steps plus random traffic
// checked against a queue-based capture model.
module tb_ddc_tail_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    ddc_tail_capture_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    // Model: 0 idle, 1 armed, 2 capturing, 3 done; captured samples in q.
    int m_state;
    int q[$];
    int m_thresh, m_len, m_irq_en, m_done, m_uflow, m_pb;

    task automatic m_reset();
        m_state = 0;
        q.delete();
        m_thresh = 0;
        m_len = 0;
        m_irq_en = 0;
        m_done = 0;
        m_uflow = 0;
        m_pb = 1;
    endtask

    function automatic int eff();
        return (m_len == 0 || m_len > 64) ? 64 : m_len;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_irq();
        chk("irq", {31'b0, irq}, 32'(m_done & m_irq_en));
    endtask

    task automatic send(input int s);
        int trig;
        @(negedge clk);
        in_data = 14'(s);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        trig = (m_pb != 0 && s >= m_thresh) ? 1 : 0;
        m_pb = (s < m_thresh) ? 1 : 0;
        if (m_state == 1 && trig != 0) begin
            q.delete();
            q.push_back(s);
            if (eff() == 1) begin
                m_state = 3;
                m_done = 1;
            end else begin
                m_state = 2;
            end
        end else if (m_state == 2) begin
            q.push_back(s);
            if (q.size() >= eff()) begin
                m_state = 3;
                m_done = 1;
            end
        end
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n = 1'b0;
        address = 3'(a);
        writedata = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        case (a)
            0: begin
                m_irq_en = int'(d[2]);
                if (d[1]) begin
                    m_state = 0;
                    q.delete();
                end else if (d[0] && (m_state == 0 || m_state == 3)) begin
                    if (m_state == 0) m_uflow = 0;
                    q.delete();
                    m_state = 1;
                end
            end
            1: begin
                if (d[2]) m_done = 0;
                if (d[3]) m_uflow = 0;
            end
            2: m_thresh = int'(d[13:0]);
            3: m_len = int'(d[6:0]);
            default: ;
        endcase
    endtask

    task automatic bus_rd(input int a, output logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1;
        read = 1'b1;
        address = 3'(a);
        @(negedge clk);
        chipselect = 1'b0;
        read = 1'b0;
        v = readdata;
    endtask

    task automatic m_read(input int a, output logic [31:0] e);
        e = '0;
        case (a)
            0: e = 32'(m_irq_en << 2);
            1: e = 32'((m_uflow << 3) | (m_done << 2) | m_state);
            2: e = 32'(m_thresh);
            3: e = 32'(m_len);
            4: begin
                if (m_state == 3 && q.size() > 0) begin
                    e = 32'(q.pop_front());
                end else begin
                    m_uflow = 1;
                end
            end
            5: e = 32'(q.size());
            default: e = '0;
        endcase
    endtask

    task automatic rd_chk(input int a, input string tag);
        logic [31:0] e, v;
        m_read(a, e);
        bus_rd(a, v);
        chk(tag, v, e);
        chk_irq();
    endtask

    task automatic rd_exp(input int a, input string tag, input logic [31:0] x);
        logic [31:0] e, v;
        m_read(a, e);
        bus_rd(a, v);
        chk(tag, v, x);
        chk({tag, "_model"}, v, e);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] d;
        int op;
        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state of every register.
        for (int a = 0; a < 8; a++) rd_exp(a, "reset_reg", 32'd0);
        chk("reset_irq", {31'b0, irq}, 32'd0);

        // Basic threshold capture.
        bus_wr(2, 32'd1000);
        bus_wr(3, 32'd4);
        bus_wr(0, 32'h5);
        rd_exp(1, "armed_status", 32'd1);
        send(500); send(1200); send(1300); send(900); send(1100); send(50);
        rd_exp(1, "done_status", 32'h7);
        chk("done_irq", {31'b0, irq}, 32'd1);
        rd_exp(5, "count4", 32'd4);
        rd_exp(4, "data0", 32'd1200);
        rd_exp(4, "data1", 32'd1300);
        rd_exp(4, "data2", 32'd900);
        rd_exp(4, "data3", 32'd1100);

        // Armed while already above threshold: needs a fresh crossing.
        send(1500);
        bus_wr(0, 32'h5);
        send(1600);
        rd_exp(1, "no_trig_status", 32'h5);
        send(800);
        rd_exp(5, "no_trig_count", 32'd0);
        send(1200); send(1); send(2); send(3);
        rd_exp(1, "retrig_status", 32'h7);
        rd_exp(4, "retrig_d0", 32'd1200);
        for (int i = 0; i < 3; i++) rd_chk(4, "retrig_d");

        // LENGTH=0 fills the whole buffer.
        bus_wr(3, 32'd0);
        bus_wr(0, 32'h5);
        send(0);
        send(2000);
        for (int i = 0; i < 63; i++) send(int'($urandom_range(0, 16383)));
        rd_exp(5, "full_count", 32'd64);
        rd_exp(1, "full_status", 32'h7);
        for (int i = 0; i < 64; i++) rd_chk(4, "full_data");

        // Drain past the end of a 4-sample capture.
        bus_wr(3, 32'd4);
        bus_wr(0, 32'h5);
        send(0); send(3000); send(7); send(8); send(9);
        for (int i = 0; i < 4; i++) rd_chk(4, "drain_data");
        rd_exp(4, "underflow_data", 32'd0);
        rd_exp(1, "underflow_status", 32'hF);

        // Abort mid-capture; done stays clear.
        bus_wr(1, 32'hC);
        bus_wr(0, 32'h5);
        send(0); send(2000); send(2100);
        rd_exp(5, "abort_pre_count", 32'd2);
        bus_wr(0, 32'h6);
        rd_exp(1, "abort_status", 32'd0);
        rd_exp(5, "abort_count", 32'd0);
        bus_wr(0, 32'h7);
        rd_exp(1, "arm_abort_status", 32'd0);

        // Random traffic against the model.
        for (int it = 0; it < 600; it++) begin
            op = int'($urandom_range(0, 11));
            if (op <= 5) begin
                send(int'($urandom_range(0, 255)));
            end else if (op == 6) begin
                d = {29'b0, 1'($urandom), 1'b0, 1'($urandom)};
                if ($urandom_range(0, 7) == 0) d[1] = 1'b1;
                bus_wr(0, d);
            end else if (op == 7) begin
                bus_wr(2, 32'($urandom_range(0, 255)));
            end else if (op == 8) begin
                bus_wr(3, $urandom);
            end else if (op == 9) begin
                bus_wr(1, $urandom);
            end else if (op == 10) begin
                rd_chk(4, "rnd_data");
            end else begin
                rd_chk(int'($urandom_range(0, 7)), "rnd_reg");
            end
            chk_irq();
        end
        for (int a = 0; a < 6; a++) if (a != 4) rd_chk(a, "rnd_final");

        // Done clear, re-arm in DONE, reset mid-capture.
        bus_wr(0, 32'h2);
        bus_wr(2, 32'd1000);
        bus_wr(3, 32'd4);
        bus_wr(0, 32'h5);
        send(0); send(2000); send(1); send(2); send(3);
        chk("done2_irq", {31'b0, irq}, 32'd1);
        bus_wr(1, 32'h4);
        chk("clr_irq", {31'b0, irq}, 32'd0);
        rd_exp(1, "clr_status", 32'h3);
        bus_wr(0, 32'h5);
        send(0); send(2000); send(1); send(2); send(3);
        bus_wr(0, 32'h5);
        rd_exp(1, "rearm_status", 32'h5);
        rd_exp(5, "rearm_count", 32'd0);
        chk("rearm_irq", {31'b0, irq}, 32'd1);
        send(0); send(2000);
        rd_exp(1, "capture_status", 32'h6);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_irq_async", {31'b0, irq}, 32'd0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        rd_exp(1, "post_reset_status", 32'd0);
        rd_exp(5, "post_reset_count", 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
